// File: rtl/mmul_dim_checker.sv
// Runtime validator for matrix-multiply shape descriptors {RA, CA, RB, CB}.
// It checks one descriptor at a time against the configured maxima and
// returns an error mask. For legal shapes it also returns the MAC count
// RA*CA*CB, which it builds with two back-to-back shift-add multiplies.
//
// Handshake rule, on both the input and output sides: a transfer happens on
// a rising clk edge where valid && ready are both high. Once valid is raised
// it is held, and the payload stays stable, until that edge.
module mmul_dim_checker #(
  parameter int DW    = 8,
  parameter int MAX_R = 64,
  parameter int MAX_K = 64,
  parameter int MAX_C = 64,
  parameter int ECW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_ra,
  input  logic [DW-1:0]   in_ca,
  input  logic [DW-1:0]   in_rb,
  input  logic [DW-1:0]   in_cb,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_ok,
  output logic [2:0]      out_err,
  output logic [3*DW-1:0] out_macs,
  output logic [ECW-1:0]  err_cnt,
  output logic            busy
);

  localparam int CW = $clog2(DW) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_MUL1,
    S_MUL2,
    S_DONE
  } state_t;

  // The state register is a named enum so checkers can bind to it directly.
  state_t state;
  state_t state_nxt;

  logic [DW-1:0]   ra, ca, rb, cb;
  logic [2:0]      err_nxt;
  logic [3*DW-1:0] mcand;
  logic [3*DW-1:0] acc;
  logic [3*DW-1:0] acc_add;
  logic [DW-1:0]   mplier;
  logic [CW-1:0]   cnt;
  logic            cnt_last;

  assign cnt_last = (cnt == CW'(DW - 1));
  assign acc_add  = acc + (mplier[0] ? mcand : '0);

  // The three error classes are evaluated independently of each other.
  always_comb begin
    err_nxt    = 3'b000;
    err_nxt[0] = (ca != rb);
    err_nxt[1] = (ra == '0) || (ca == '0) || (rb == '0) || (cb == '0);
    err_nxt[2] = (32'(ra) > MAX_R) || (32'(ca) > MAX_K) ||
                 (32'(rb) > MAX_K) || (32'(cb) > MAX_C);
  end

  // State register. An asynchronous reset drops any descriptor in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. Each multiply phase takes exactly DW cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)    state_nxt = S_CHECK;
      S_CHECK: state_nxt = (err_nxt != 3'b000) ? S_DONE : S_MUL1;
      S_MUL1:  if (cnt_last)    state_nxt = S_MUL2;
      S_MUL2:  if (cnt_last)    state_nxt = S_DONE;
      S_DONE:  if (out_ready)   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: field capture, error mask, and the two shift-add multiplies.
  // The multiplies are p1 = RA*CB and then p1*CA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra       <= '0;
      ca       <= '0;
      rb       <= '0;
      cb       <= '0;
      mcand    <= '0;
      acc      <= '0;
      mplier   <= '0;
      cnt      <= '0;
      out_ok   <= 1'b0;
      out_err  <= 3'b000;
      out_macs <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            ra <= in_ra;
            ca <= in_ca;
            rb <= in_rb;
            cb <= in_cb;
          end
        end
        S_CHECK: begin
          out_err  <= err_nxt;
          out_ok   <= 1'b0;
          out_macs <= '0;
          mcand    <= {{(2*DW){1'b0}}, ra};
          mplier   <= cb;
          acc      <= '0;
          cnt      <= '0;
        end
        S_MUL1: begin
          if (cnt_last) begin
            // p1 becomes the multiplicand of the second pass, with CA as the multiplier.
            mcand  <= acc_add;
            mplier <= ca;
            acc    <= '0;
            cnt    <= '0;
          end else begin
            acc    <= acc_add;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
          end
        end
        S_MUL2: begin
          if (cnt_last) begin
            out_macs <= acc_add;
            out_ok   <= 1'b1;
          end else begin
            acc    <= acc_add;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Count error results when they are delivered, and stop at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if ((state == S_DONE) && out_ready && !out_ok && (err_cnt != '1))
      err_cnt <= err_cnt + ECW'(1);
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

endmodule
